l3_arbiter: RTL and testbench

- Shares the single L3 cache port between up to four cores.
- Each core's L1/L2 hierarchy raises L3 read/write requests. The arbiter picks one by round-robin, drives the shared L3 port, waits for the response, and returns data to the winning core.
- Only one transaction is outstanding at a time.
- Sits between the per-core cache hierarchies and the shared L3 instance.

---
 rtl/l3_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_l3_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l3_arbiter.sv
// Round-robin arbiter sharing one L3 cache port between up to four cores.
// One transaction is outstanding at a time; a stuck L3 response is aborted after TIMEOUT cycles.
module l3_arbiter #(
    parameter int unsigned NUM_CORES  = 4,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_CORES*ADDR_WIDTH-1:0]  core_addr,
    input  logic [NUM_CORES-1:0]             core_read_enable,
    input  logic [NUM_CORES-1:0]             core_write_enable,
    input  logic [NUM_CORES*DATA_WIDTH-1:0]  core_write_data,
    output logic [DATA_WIDTH-1:0]            core_read_data,
    output logic [NUM_CORES-1:0]             core_valid,
    output logic                             core_error,
    output logic                             core_ready,
    output logic [ADDR_WIDTH-1:0]            l3_addr,
    output logic                             l3_read_enable,
    output logic                             l3_write_enable,
    output logic [DATA_WIDTH-1:0]            l3_write_data,
    input  logic [DATA_WIDTH-1:0]            l3_read_data,
    input  logic                             l3_valid,
    input  logic                             l3_ready,
    output logic [1:0]                       grant_id,
    output logic                             busy
);

    localparam int unsigned TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [1:0]            r_last;
    logic [1:0]            r_grant;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_cmd_wr;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_err;
    logic [TW-1:0]         r_timer;

    // Per-core views padded to four entries so a 2-bit index is always in range.
    logic [3:0]            w_req4;
    logic [3:0]            w_wr4;
    logic [ADDR_WIDTH-1:0] w_addr_arr  [4];
    logic [DATA_WIDTH-1:0] w_wdata_arr [4];

    logic [1:0]            w_scan;
    logic [1:0]            w_pick;
    logic                  w_any;
    logic                  w_timeout;
    logic [3:0]            w_onehot;

    for (genvar g = 0; g < 4; g++) begin : g_core
        if (g < NUM_CORES) begin : g_live
            assign w_req4[g]      = core_read_enable[g] | core_write_enable[g];
            assign w_wr4[g]       = core_write_enable[g];
            assign w_addr_arr[g]  = core_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
            assign w_wdata_arr[g] = core_write_data[g*DATA_WIDTH +: DATA_WIDTH];
        end else begin : g_pad
            assign w_req4[g]      = 1'b0;
            assign w_wr4[g]       = 1'b0;
            assign w_addr_arr[g]  = '0;
            assign w_wdata_arr[g] = '0;
        end
    end

    function automatic logic [1:0] f_next(input logic [1:0] cur);
        f_next = (cur == 2'(NUM_CORES - 1)) ? 2'd0 : cur + 2'd1;
    endfunction

    // Scan starts one past the last winner and wraps modulo NUM_CORES.
    always_comb begin
        w_any  = 1'b0;
        w_pick = r_last;
        w_scan = r_last;
        for (int unsigned k = 0; k < NUM_CORES; k++) begin
            w_scan = f_next(w_scan);
            if (!w_any && w_req4[w_scan]) begin
                w_any  = 1'b1;
                w_pick = w_scan;
            end
        end
    end

    assign w_timeout = (r_state == S_WAIT) && !l3_valid && (r_timer == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_any)                 w_next = S_ISSUE;
            S_ISSUE: if (l3_ready)              w_next = S_WAIT;
            S_WAIT:  if (l3_valid || w_timeout) w_next = S_RESP;
            S_RESP:                             w_next = S_IDLE;
            default:                            w_next = S_IDLE;
        endcase
    end

    assign w_onehot = 4'b0001 << r_grant;

    always_comb begin
        core_ready      = 1'b0;
        busy            = 1'b1;
        l3_read_enable  = 1'b0;
        l3_write_enable = 1'b0;
        core_valid      = '0;
        core_error      = 1'b0;
        case (r_state)
            S_IDLE: begin
                core_ready = 1'b1;
                busy       = 1'b0;
            end
            S_ISSUE: begin
                l3_read_enable  = !r_cmd_wr;
                l3_write_enable = r_cmd_wr;
            end
            S_RESP: begin
                core_valid = w_onehot[NUM_CORES-1:0];
                core_error = r_err;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last   <= 2'(NUM_CORES - 1);
            r_grant  <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_cmd_wr <= 1'b0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
            r_timer  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_grant  <= w_pick;
                        r_addr   <= w_addr_arr[w_pick];
                        r_wdata  <= w_wdata_arr[w_pick];
                        r_cmd_wr <= w_wr4[w_pick];
                    end
                end
                S_ISSUE: begin
                    if (l3_ready) begin
                        r_timer <= '0;
                    end
                end
                S_WAIT: begin
                    if (l3_valid) begin
                        r_rdata <= l3_read_data;
                        r_err   <= 1'b0;
                    end else if (w_timeout) begin
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_RESP: begin
                    r_last <= r_grant;
                end
                default: ;
            endcase
        end
    end

    assign grant_id       = r_grant;
    assign core_read_data = r_rdata;
    assign l3_addr        = r_addr;
    assign l3_write_data  = r_wdata;

    a_valid_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(core_valid));
    a_single_cmd:   assert property (@(posedge clk) disable iff (!rst) !(l3_read_enable && l3_write_enable));

endmodule

// File: tb/tb_l3_arbiter.sv
// Bench for l3_arbiter: directed scenarios with literal expectations, then randomized
// traffic checked every cycle against a transaction-level model of the arbiter.
module tb_l3_arbiter;

    localparam int NC = 4;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int TO = 64;

    logic             clk = 1'b0;
    logic             rst;
    logic [NC*AW-1:0] core_addr;
    logic [NC-1:0]    core_read_enable;
    logic [NC-1:0]    core_write_enable;
    logic [NC*DW-1:0] core_write_data;
    logic [DW-1:0]    core_read_data;
    logic [NC-1:0]    core_valid;
    logic             core_error;
    logic             core_ready;
    logic [AW-1:0]    l3_addr;
    logic             l3_read_enable;
    logic             l3_write_enable;
    logic [DW-1:0]    l3_write_data;
    logic [DW-1:0]    l3_read_data;
    logic             l3_valid;
    logic             l3_ready;
    logic [1:0]       grant_id;
    logic             busy;

    always #5 clk = ~clk;

    l3_arbiter #(
        .NUM_CORES (NC),
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .TIMEOUT   (TO)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .core_addr        (core_addr),
        .core_read_enable (core_read_enable),
        .core_write_enable(core_write_enable),
        .core_write_data  (core_write_data),
        .core_read_data   (core_read_data),
        .core_valid       (core_valid),
        .core_error       (core_error),
        .core_ready       (core_ready),
        .l3_addr          (l3_addr),
        .l3_read_enable   (l3_read_enable),
        .l3_write_enable  (l3_write_enable),
        .l3_write_data    (l3_write_data),
        .l3_read_data     (l3_read_data),
        .l3_valid         (l3_valid),
        .l3_ready         (l3_ready),
        .grant_id         (grant_id),
        .busy             (busy)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Transaction-level model: which core owns the port, and where its transaction stands.
    typedef enum {M_IDLE, M_CMD, M_AWAIT, M_DONE} mstage_t;
    mstage_t       m_stage;
    int            m_owner;
    int            m_last;
    int            m_waited;
    bit            m_write;
    bit            m_err;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;
    int            m_pick;

    function automatic int pick(input int last, input logic [NC-1:0] req);
        int c;
        pick = -1;
        for (int k = 1; k <= NC; k++) begin
            c = (last + k) % NC;
            if (pick < 0 && req[c]) pick = c;
        end
    endfunction

    assign m_pick = pick(m_last, core_read_enable | core_write_enable);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_stage  <= M_IDLE;
            m_owner  <= 0;
            m_last   <= NC - 1;
            m_waited <= 0;
            m_write  <= 1'b0;
            m_err    <= 1'b0;
            m_addr   <= '0;
            m_wdata  <= '0;
            m_rdata  <= '0;
        end else begin
            case (m_stage)
                M_IDLE: if (m_pick >= 0) begin
                    m_owner <= m_pick;
                    m_write <= core_write_enable[m_pick];
                    m_addr  <= core_addr[m_pick*AW +: AW];
                    m_wdata <= core_write_data[m_pick*DW +: DW];
                    m_stage <= M_CMD;
                end
                M_CMD: if (l3_ready) begin
                    m_waited <= 0;
                    m_stage  <= M_AWAIT;
                end
                M_AWAIT: begin
                    m_waited <= m_waited + 1;
                    if (l3_valid) begin
                        m_rdata <= l3_read_data;
                        m_err   <= 1'b0;
                        m_stage <= M_DONE;
                    end else if (m_waited + 1 == TO) begin
                        m_rdata <= '0;
                        m_err   <= 1'b1;
                        m_stage <= M_DONE;
                    end
                end
                M_DONE: begin
                    m_last  <= m_owner;
                    m_stage <= M_IDLE;
                end
                default: m_stage <= M_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        if (rst && chk_en) begin
            check("core_ready", 32'(core_ready), 32'(m_stage == M_IDLE));
            check("busy", 32'(busy), 32'(m_stage != M_IDLE));
            check("grant_id", 32'(grant_id), 32'(m_owner));
            check("core_valid", 32'(core_valid), (m_stage == M_DONE) ? (32'd1 << m_owner) : 32'd0);
            check("core_error", 32'(core_error), 32'(m_stage == M_DONE && m_err));
            check("core_read_data", 32'(core_read_data), 32'(m_rdata));
            check("l3_read_enable", 32'(l3_read_enable), 32'(m_stage == M_CMD && !m_write));
            check("l3_write_enable", 32'(l3_write_enable), 32'(m_stage == M_CMD && m_write));
            if (m_stage == M_CMD) begin
                check("l3_addr", 32'(l3_addr), 32'(m_addr));
                check("l3_write_data", 32'(l3_write_data), 32'(m_wdata));
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        core_addr         = '0;
        core_read_enable  = '0;
        core_write_enable = '0;
        core_write_data   = '0;
        l3_read_data      = '0;
        l3_valid          = 1'b0;
        l3_ready          = 1'b1;
    endtask

    task automatic set_req(input int c, input bit rd, input bit wr, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        core_read_enable[c]       = rd;
        core_write_enable[c]      = wr;
        core_addr[c*AW +: AW]     = a;
        core_write_data[c*DW +: DW] = d;
    endtask

    // Cores hold requests until served and drop them while core_valid is high.
    task automatic rand_drive(input bit quiet);
        int r;
        for (int i = 0; i < NC; i++) begin
            if (core_valid[i]) begin
                core_read_enable[i]  = 1'b0;
                core_write_enable[i] = 1'b0;
            end else if (!(core_read_enable[i] | core_write_enable[i]) && $urandom_range(0, 3) == 0) begin
                r = $urandom_range(0, 2);
                set_req(i, r != 1, r != 0, AW'($urandom), DW'($urandom));
            end
        end
        l3_ready     = ($urandom_range(0, 3) != 0);
        l3_valid     = quiet ? 1'b0 : ($urandom_range(0, 2) == 0);
        l3_read_data = DW'($urandom);
    endtask

    int got_rr[$];
    int exp_rr[5] = '{0, 1, 2, 3, 0};
    int waits;
    int guard;
    int n_acc;

    initial begin
        rst = 1'b0;
        clear_inputs();
        repeat (3) tick();

        check("rst_core_ready", 32'(core_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_core_valid", 32'(core_valid), 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd0);
        check("rst_l3_cmd", 32'({l3_read_enable, l3_write_enable}), 32'd0);
        check("rst_l3_addr", 32'(l3_addr), 32'd0);
        check("rst_read_data", 32'(core_read_data), 32'd0);

        rst    = 1'b1;
        chk_en = 1'b1;

        // Single read by core 1: response lands in the fourth cycle.
        set_req(1, 1'b1, 1'b0, 8'h3C, 8'h00);
        tick();
        check("rd_issue_en", 32'(l3_read_enable), 32'd1);
        check("rd_issue_addr", 32'(l3_addr), 32'h3C);
        tick();
        check("rd_en_dropped", 32'(l3_read_enable), 32'd0);
        l3_valid     = 1'b1;
        l3_read_data = 8'hA5;
        tick();
        check("rd_valid", 32'(core_valid), 32'b0010);
        check("rd_data", 32'(core_read_data), 32'hA5);
        check("rd_error", 32'(core_error), 32'd0);
        set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
        l3_valid = 1'b0;
        tick();
        check("rd_valid_pulse", 32'(core_valid), 32'd0);
        check("rd_data_hold", 32'(core_read_data), 32'hA5);

        // Write by core 2.
        set_req(2, 1'b0, 1'b1, 8'h10, 8'h77);
        tick();
        check("wr_issue_en", 32'({l3_write_enable, l3_read_enable}), 32'b10);
        check("wr_issue_addr", 32'(l3_addr), 32'h10);
        check("wr_issue_data", 32'(l3_write_data), 32'h77);
        tick();
        l3_valid = 1'b1;
        tick();
        check("wr_valid", 32'(core_valid), 32'b0100);
        set_req(2, 1'b0, 1'b0, 8'h00, 8'h00);
        l3_valid = 1'b0;
        tick();

        // Round-robin from reset with all cores requesting continuously.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        for (int i = 0; i < NC; i++) set_req(i, 1'b1, 1'b0, AW'(8'h11 * (i + 1)), 8'h00);
        l3_ready     = 1'b1;
        l3_valid     = 1'b1;
        l3_read_data = 8'h42;
        for (int t = 0; t < 40 && got_rr.size() < 5; t++) begin
            tick();
            if (core_valid != 0) begin
                check("rr_onehot", 32'($onehot(core_valid)), 32'd1);
                for (int i = 0; i < NC; i++) if (core_valid[i]) got_rr.push_back(i);
            end
        end
        for (int k = 0; k < 5; k++)
            check("rr_grant_order", (k < got_rr.size()) ? 32'(got_rr[k]) : 32'hFFFF_FFFF, 32'(exp_rr[k]));
        core_read_enable = '0;
        repeat (5) tick();
        l3_valid = 1'b0;

        // Backpressure on a write by core 3.
        set_req(3, 1'b0, 1'b1, 8'h5A, 8'hC3);
        l3_ready = 1'b0;
        n_acc    = 0;
        tick();
        for (int t = 0; t < 6; t++) begin
            check("bp_cmd_held", 32'(l3_write_enable), 32'd1);
            check("bp_addr_held", 32'(l3_addr), 32'h5A);
            check("bp_data_held", 32'(l3_write_data), 32'hC3);
            check("bp_busy", 32'(busy), 32'd1);
            if (t == 5) l3_ready = 1'b1;
            if (l3_write_enable && l3_ready) n_acc++;
            tick();
        end
        for (int t = 0; t < 3; t++) begin
            check("bp_cmd_released", 32'(l3_write_enable), 32'd0);
            check("bp_busy_wait", 32'(busy), 32'd1);
            if (l3_write_enable && l3_ready) n_acc++;
            tick();
        end
        check("bp_accept_count", 32'(n_acc), 32'd1);
        l3_valid = 1'b1;
        tick();
        check("bp_valid", 32'(core_valid), 32'b1000);
        set_req(3, 1'b0, 1'b0, 8'h00, 8'h00);
        l3_valid = 1'b0;
        tick();

        // Timeout: L3 never answers core 0.
        set_req(0, 1'b1, 1'b0, 8'h22, 8'h00);
        l3_read_data = 8'hFF;
        tick();
        tick();
        waits = 0;
        while (core_valid == 0 && waits < 200) begin
            waits++;
            tick();
        end
        check("to_wait_cycles", 32'(waits), 32'd64);
        check("to_valid", 32'(core_valid), 32'b0001);
        check("to_error", 32'(core_error), 32'd1);
        check("to_data_zero", 32'(core_read_data), 32'd0);
        set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
        tick();
        set_req(2, 1'b1, 1'b0, 8'h33, 8'h00);
        tick();
        tick();
        l3_valid     = 1'b1;
        l3_read_data = 8'h5E;
        tick();
        check("to_next_valid", 32'(core_valid), 32'b0100);
        check("to_next_error", 32'(core_error), 32'd0);
        check("to_next_data", 32'(core_read_data), 32'h5E);
        set_req(2, 1'b0, 1'b0, 8'h00, 8'h00);
        l3_valid = 1'b0;
        tick();

        // Asynchronous reset while waiting on L3.
        set_req(1, 1'b1, 1'b0, 8'h44, 8'h00);
        repeat (3) tick();
        #2 rst = 1'b0;
        #1;
        check("ar_core_ready", 32'(core_ready), 32'd1);
        check("ar_busy", 32'(busy), 32'd0);
        check("ar_core_valid", 32'(core_valid), 32'd0);
        check("ar_grant_id", 32'(grant_id), 32'd0);
        set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
        tick();
        set_req(0, 1'b1, 1'b0, 8'h01, 8'h00);
        set_req(3, 1'b1, 1'b0, 8'h03, 8'h00);
        l3_valid = 1'b1;
        rst      = 1'b1;
        guard    = 0;
        while (core_valid == 0 && guard < 20) begin
            guard++;
            tick();
        end
        check("ar_first_winner", 32'(core_valid), 32'b0001);
        clear_inputs();
        repeat (6) tick();

        // Randomized traffic, with a stretch where L3 stays silent to force timeouts.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rand_drive(cyc >= 1000 && cyc < 1200);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
